// File: rtl/clkgate_ctrl.sv
// Enable controller for a latch-based clock-gate cell: drops E after a
// programmable idle window and restores it on activity, wake request or test.
module clkgate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic       CK,
  input  logic       RN,
  input  logic       busy,
  input  logic       sleep_en,
  input  logic       te,
  input  logic       wake_req,
  output logic       wake_ack,
  output logic       E,
  output logic       gated,
  output logic [1:0] state
);

  // Illegal parameters stop elaboration.
  if (IDLE_CYCLES < 2 || IDLE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_idle
    $error("clkgate_ctrl: IDLE_CYCLES out of range");
  end
  if (WAKE_CYCLES < 1 || WAKE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_wake
    $error("clkgate_ctrl: WAKE_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    IDLE = 2'd1,
    OFF  = 2'd2,
    WAKE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_d, gated_d, ack_d;
  logic             qual;

  // Handshake: wake_req is a 4-phase request; it is raised and held until
  // wake_ack is seen high, then dropped; wake_ack is high only in RUN (clock
  // guaranteed running) and falls on the edge after wake_req falls.
  assign qual = sleep_en & ~busy & ~wake_req & ~te;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_d     = E;
    gated_d = gated;
    ack_d   = 1'b0;
    case (state_q)
      RUN: begin
        e_d     = 1'b1;
        gated_d = 1'b0;
        ack_d   = wake_req;
        if (qual) begin
          state_d = IDLE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      IDLE: begin
        if (!qual) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = OFF;
          e_d     = 1'b0;
          gated_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      OFF: begin
        // Test override skips the wake delay entirely.
        if (te) begin
          state_d = RUN;
          e_d     = 1'b1;
          gated_d = 1'b0;
          cnt_d   = '0;
        end else if (busy || wake_req) begin
          state_d = WAKE;
          e_d     = 1'b1;
          gated_d = 1'b0;
          cnt_d   = '0;
        end
      end
      WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RUN;
        e_d     = 1'b1;
        gated_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // E comes straight from a flop so it is glitch-free through CK low.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      E        <= 1'b1;
      gated    <= 1'b0;
      wake_ack <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      E        <= e_d;
      gated    <= gated_d;
      wake_ack <= ack_d;
    end
  end

  assign state = state_q;

endmodule
